// File: rtl/port_stat_bank_pkg.sv
// Shared types, widths and the saturating adder for the statistics counter bank.
package stat_pkg;

   localparam int STAT_AW    = 7;
   localparam int STAT_DW    = 32;
   localparam int STAT_IW    = 16;
   localparam int STAT_DEPTH = 128;

   typedef enum logic [2:0] {
      S_CLR,
      S_IDLE,
      S_RD,
      S_WR,
      S_CRD,
      S_CWR,
      S_GAP
   } stat_state_e;

   // A carry out of bit 31 pins the counter at all-ones instead of wrapping.
   function automatic logic [STAT_DW-1:0] sat_add(input logic [STAT_DW-1:0] acc,
                                                 input logic [STAT_IW-1:0] inc);
      logic [STAT_DW:0] sum;
      sum = {1'b0, acc} + {{(STAT_DW-STAT_IW+1){1'b0}}, inc};
      return sum[STAT_DW] ? {STAT_DW{1'b1}} : sum[STAT_DW-1:0];
   endfunction

endpackage

// File: rtl/port_stat_bank_if.sv
// Port-update and CPU-read handshake bundle for port_stat_bank.
interface port_stat_bank_if
   import stat_pkg::*;
#(
   parameter int NPORTS = 4
);
   logic [NPORTS*STAT_AW-1:0] port_addr;
   logic [NPORTS*STAT_IW-1:0] port_din;
   logic [NPORTS-1:0]         port_req;
   logic [NPORTS-1:0]         port_ack;
   logic [STAT_AW-1:0]        cpu_addr;
   logic                      cpu_req;
   logic                      cpu_ack;
   logic [STAT_DW-1:0]        cpu_dout;

   modport master (
      output port_addr, port_din, port_req, cpu_addr, cpu_req,
      input  port_ack, cpu_ack, cpu_dout
   );

   modport slave (
      input  port_addr, port_din, port_req, cpu_addr, cpu_req,
      output port_ack, cpu_ack, cpu_dout
   );
endinterface

// File: rtl/port_stat_bank_arb.sv
// stat_rr_arb: combinational round-robin pick, searching upward from last_grant+1.
module stat_rr_arb #(
   parameter int NPORTS = 4,
   localparam int GW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic [NPORTS-1:0] req,
   input  logic [GW-1:0]     last_grant,
   output logic [GW-1:0]     grant,
   output logic              any_req
);

   logic found;
   int   idx;

   always_comb begin
      grant   = '0;
      any_req = |req;
      found   = 1'b0;
      idx     = 0;
      // The previous winner is examined last, so it cannot starve its neighbours.
      for (int k = 1; k <= NPORTS; k++) begin
         idx = (int'(last_grant) + k) % NPORTS;
         if (!found && req[idx]) begin
            grant = GW'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/port_stat_bank.sv
// 128 x 32-bit saturating per-port statistics bank with round-robin port updates and CPU reads.
// Build option: STAT_CLR_ON_READ_EN turns CPU reads into atomic read-and-clear.
module port_stat_bank
   import stat_pkg::*;
#(
   parameter int NPORTS = 4
) (
   input  logic             clk,
   input  logic             rst,
   port_stat_bank_if.slave  bus,
   output logic             init_done
);

   localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   stat_state_e          state;
   logic [STAT_AW-1:0]   clr_idx;
   logic [STAT_AW-1:0]   lat_addr;
   logic [STAT_IW-1:0]   lat_din;
   logic [GW-1:0]        last_grant;
   logic [GW-1:0]        grant;
   logic [GW-1:0]        grant_q;
   logic                 any_req;
   logic [NPORTS-1:0]    port_ack_q;
   logic                 cpu_ack_q;
   logic [STAT_DW-1:0]   dout_q;

   logic [STAT_DW-1:0]   mem [STAT_DEPTH];
   logic [STAT_DW-1:0]   rdata;
   logic                 re;
   logic                 we;
   logic [STAT_AW-1:0]   waddr;
   logic [STAT_DW-1:0]   wdata;

   stat_rr_arb #(.NPORTS(NPORTS)) u_arb (
      .req        (bus.port_req),
      .last_grant (last_grant),
      .grant      (grant),
      .any_req    (any_req)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_CLR;
         clr_idx    <= '0;
         init_done  <= 1'b0;
         last_grant <= GW'(NPORTS-1);
         grant_q    <= '0;
         lat_addr   <= '0;
         lat_din    <= '0;
         port_ack_q <= '0;
         cpu_ack_q  <= 1'b0;
         dout_q     <= '0;
      end else begin
         port_ack_q <= '0;
         cpu_ack_q  <= 1'b0;
         case (state)
            S_CLR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == STAT_AW'(STAT_DEPTH-1)) begin
                  state     <= S_IDLE;
                  init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.cpu_req) begin
                  lat_addr <= bus.cpu_addr;
                  state    <= S_CRD;
               end else if (any_req) begin
                  grant_q  <= grant;
                  lat_addr <= bus.port_addr[int'(grant)*STAT_AW +: STAT_AW];
                  lat_din  <= bus.port_din[int'(grant)*STAT_IW +: STAT_IW];
                  state    <= S_RD;
               end
            end
            // Acks are set one cycle early so they line up with the WR/CWR cycle.
            S_RD: begin
               port_ack_q[grant_q] <= 1'b1;
               state               <= S_WR;
            end
            S_WR: begin
               last_grant <= grant_q;
               state      <= S_GAP;
            end
            S_CRD: begin
               cpu_ack_q <= 1'b1;
               state     <= S_CWR;
            end
            S_CWR: begin
               dout_q <= rdata;
               state  <= S_GAP;
            end
            S_GAP:   state <= S_IDLE;
            default: state <= S_CLR;
         endcase
      end
   end

   assign re    = (state == S_RD) || (state == S_CRD);

   always_comb begin
      we    = 1'b0;
      waddr = lat_addr;
      wdata = sat_add(rdata, lat_din);
      case (state)
         S_CLR: begin
            we    = 1'b1;
            waddr = clr_idx;
            wdata = '0;
         end
         S_WR: we = 1'b1;
`ifdef STAT_CLR_ON_READ_EN
         S_CWR: begin
            we    = 1'b1;
            wdata = '0;
         end
`else
         S_CWR: we = 1'b0;
`endif
         default: we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[lat_addr];
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // RAM data is only available in CWR, so it bypasses the holding register there.
   assign bus.cpu_dout = (state == S_CWR) ? rdata : dout_q;
   assign bus.port_ack = port_ack_q;
   assign bus.cpu_ack  = cpu_ack_q;

endmodule

// File: tb/tb_port_stat_bank.sv
// Directed self-checking bench for port_stat_bank (4 ports).
module tb_port_stat_bank;

   logic clk = 1'b0;
   logic rst;
   logic init_done;
   int   n_tests = 0;
   int   n_fail  = 0;

   port_stat_bank_if #(.NPORTS(4)) bus ();

   port_stat_bank #(.NPORTS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [6:0] a, input logic [31:0] v);
      dut.mem[a] <= v;
      tick();
   endtask

   task automatic port_upd(input int p, input logic [6:0] a, input logic [15:0] d,
                           output int lat);
      bus.port_addr[p*7 +: 7]   = a;
      bus.port_din[p*16 +: 16]  = d;
      bus.port_req[p]           = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.port_ack[p] && lat < 40);
      chk("port_ack_seen", 32'(bus.port_ack[p]), 32'd1);
      bus.port_req[p] = 1'b0;
      tick();
      chk("port_ack_one_cycle", 32'(bus.port_ack), 32'd0);
      tick();
   endtask

   task automatic cpu_rd(input logic [6:0] a, output logic [31:0] data, output int lat);
      bus.cpu_addr = a;
      bus.cpu_req  = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.cpu_ack && lat < 40);
      chk("cpu_ack_seen", 32'(bus.cpu_ack), 32'd1);
      data = bus.cpu_dout;
      bus.cpu_req = 1'b0;
      tick();
      chk("cpu_dout_hold", bus.cpu_dout, data);
      chk("cpu_ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
      tick();
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      int          cnt;
      int          c, last_c, first_c, nack, exp_p, c_cpu, c_port;
      logic [3:0]  redo;
      logic [3:0]  ack_seen;

      rst           = 1'b1;
      bus.port_addr = '0;
      bus.port_din  = '0;
      bus.port_req  = '0;
      bus.cpu_addr  = '0;
      bus.cpu_req   = 1'b0;
      repeat (3) tick();
      chk("rst_port_ack", 32'(bus.port_ack), 32'd0);
      chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
      chk("rst_cpu_dout", bus.cpu_dout, 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);

      // clear sweep length
      rst = 1'b0;
      cnt = 0;
      while (!init_done && cnt < 300) begin
         tick();
         cnt++;
      end
      chk("init_cycles", 32'(cnt), 32'd128);
      cpu_rd(7'h7F, d, lat);
      chk("rd7f_val", d, 32'd0);
      chk("rd7f_lat", 32'(lat), 32'd2);

      // all four ports requesting: strict rotation 0,1,2,3,0,... every 4 cycles
      for (int i = 0; i < 4; i++) begin
         bus.port_addr[i*7 +: 7]  = 7'(8'h40 + i);
         bus.port_din[i*16 +: 16] = 16'(i + 1);
      end
      bus.port_req = 4'hF;
      c = 0; last_c = 0; first_c = 0; nack = 0; exp_p = 0; redo = '0;
      while (nack < 8 && c < 80) begin
         tick();
         c++;
         bus.port_req = bus.port_req | redo;
         redo = '0;
         if (|bus.port_ack) begin
            chk("rr_order", 32'(bus.port_ack), 32'(1 << exp_p));
            if (nack > 0) chk("rr_spacing", 32'(c - last_c), 32'd4);
            else first_c = c;
            last_c = c;
            exp_p  = (exp_p + 1) % 4;
            nack++;
            redo = bus.port_ack;
            bus.port_req = bus.port_req & ~bus.port_ack;
         end
      end
      bus.port_req = '0;
      chk("rr_ack_count", 32'(nack), 32'd8);
      chk("rr_first_lat", 32'(first_c), 32'd2);
      tick(); tick();
      cpu_rd(7'h42, d, lat);
      chk("rr_cnt42", d, 32'd6);

      // port 1 accumulates 3 x 5 into 0x10
      for (int i = 0; i < 3; i++) begin
         port_upd(1, 7'h10, 16'd5, lat);
         chk("p1_lat", 32'(lat), 32'd2);
      end
      cpu_rd(7'h10, d, lat);
      chk("p1_sum", d, 32'd15);
      port_upd(2, 7'h10, 16'd0, lat);
      chk("zero_inc_lat", 32'(lat), 32'd2);
      cpu_rd(7'h10, d, lat);
      chk("zero_inc_val", d, 32'd15);

      // saturation
      preload(7'h20, 32'hFFFF_FFF0);
      port_upd(0, 7'h20, 16'h0020, lat);
      cpu_rd(7'h20, d, lat);
      chk("sat_first", d, 32'hFFFF_FFFF);
      port_upd(3, 7'h20, 16'hFFFF, lat);
      cpu_rd(7'h20, d, lat);
      chk("sat_hold", d, 32'hFFFF_FFFF);
      preload(7'h21, 32'hFFFF_FFFE);
      port_upd(2, 7'h21, 16'd1, lat);
      cpu_rd(7'h21, d, lat);
      chk("sat_exact", d, 32'hFFFF_FFFF);

      // CPU beats a simultaneous port request
      port_upd(1, 7'h30, 16'd3, lat);
      bus.cpu_addr = 7'h30;
      bus.cpu_req  = 1'b1;
      bus.port_addr[2*7 +: 7]   = 7'h30;
      bus.port_din[2*16 +: 16]  = 16'd7;
      bus.port_req[2]           = 1'b1;
      c = 0; c_cpu = 0; c_port = 0;
      while ((c_cpu == 0 || c_port == 0) && c < 40) begin
         tick();
         c++;
         if (bus.cpu_ack) begin
            c_cpu = c;
            chk("prio_cpu_val", bus.cpu_dout, 32'd3);
            bus.cpu_req = 1'b0;
         end
         if (bus.port_ack[2]) begin
            c_port = c;
            bus.port_req[2] = 1'b0;
         end
      end
      chk("prio_cpu_lat", 32'(c_cpu), 32'd2);
      chk("prio_port_lat", 32'(c_port), 32'd6);
      tick(); tick();
      cpu_rd(7'h30, d, lat);
`ifdef STAT_CLR_ON_READ_EN
      chk("prio_second_rd", d, 32'd7);
      cpu_rd(7'h30, d, lat);
      chk("clr_on_read", d, 32'd0);
`else
      chk("prio_second_rd", d, 32'd10);
      cpu_rd(7'h30, d, lat);
      chk("nondestructive_rd", d, 32'd10);
`endif

      // reset in the RD cycle of a port update
      port_upd(0, 7'h50, 16'd9, lat);
      cpu_rd(7'h50, d, lat);
      chk("pre_rst_val", d, 32'd9);
      bus.port_addr[0 +: 7]  = 7'h50;
      bus.port_din[0 +: 16]  = 16'd4;
      bus.port_req[0]        = 1'b1;
      tick();
      chk("rd_no_ack", 32'(bus.port_ack), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.port_req[0] = 1'b0;
      bus.port_addr[7 +: 7]  = 7'h51;
      bus.port_din[16 +: 16] = 16'd2;
      bus.port_req[1]        = 1'b1;
      chk("rst_mid_dout", bus.cpu_dout, 32'd0);
      chk("rst_mid_init", 32'(init_done), 32'd0);
      ack_seen = bus.port_ack;
      cnt = 0;
      while (!init_done && cnt < 300) begin
         tick();
         cnt++;
         ack_seen |= bus.port_ack;
      end
      chk("resweep_cycles", 32'(cnt), 32'd128);
      chk("no_ack_in_sweep", 32'(ack_seen), 32'd0);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.port_ack[1] && lat < 40);
      chk("pending_after_sweep_lat", 32'(lat), 32'd2);
      bus.port_req[1] = 1'b0;
      tick(); tick();
      cpu_rd(7'h50, d, lat);
      chk("rst_cnt50", d, 32'd0);
      cpu_rd(7'h51, d, lat);
      chk("rst_cnt51", d, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/port_stat_bank.md
# port_stat_bank

Per-port statistics counter bank that sits directly downstream of each MAC's status-to-register stage. It accepts increment requests (7-bit counter address and 16-bit increment) from NPORTS MAC ports over the port_req/port_ack handshake. It accumulates them into 128 saturating 32-bit counters and serves CPU reads of any counter. Round-robin arbitration keeps all ports fair; CPU accesses take priority over port updates.

## Interface
Parameters:
- NPORTS, 4: number of MAC ports feeding the bank.

Ports:
- clk  in  1  single clock; all logic synchronous to it.
- rst  in  1  reset; synchronous, active-high.
- port_addr  in  NPORTS*7  counter address; port i occupies bits [7i+6:7i].
- port_din  in  NPORTS*16  increment value; port i occupies bits [16i+15:16i].
- port_req  in  NPORTS  per-port update request (level).
- port_ack  out  NPORTS  per-port one-cycle acknowledge.
- cpu_addr  in  7  counter to read.
- cpu_req  in  1  read request (level).
- cpu_ack  out  1  one-cycle acknowledge; cpu_dout is valid in the same cycle.
- cpu_dout  out  32  counter value; held until the next cpu_ack.
- init_done  out  1  high once the post-reset clear sweep has completed.

## Operation
- Storage: 128 x 32-bit counter array, modelled as a synchronous-read RAM (one read port, one write port).
- States: CLR, IDLE, RD, WR, CRD, CWR, GAP.
- CLR: entered on reset. A 7-bit sweep index writes 0 to addresses 0..127, one per cycle, then moves to IDLE and sets init_done. No acks are issued during CLR; requests stay pending.
- IDLE:
  - If cpu_req: latch cpu_addr, go to CRD.
  - Else if any port_req: grant round-robin, searching from (last_grant+1) mod NPORTS. Latch that port's addr and din, go to RD.
  - Else stay in IDLE.
- RD: issue the RAM read of the latched address, then go to WR.
- WR:
  - Write sat(rdata + zero_extended(din)).
  - Pulse port_ack[grant] for exactly one cycle.
  - Update last_grant, go to GAP.
- CRD: issue the RAM read, then go to CWR.
- CWR: load cpu_dout with rdata, pulse cpu_ack, go to GAP.
- GAP: one idle cycle so requesters can deassert their req after ack. Then go to IDLE.
- Saturation: if the 33-bit sum exceeds 32'hFFFF_FFFF, the stored value is 32'hFFFF_FFFF. A counter never wraps.
- Requester rules:
  - addr and din must be held stable while req is high.
  - req must deassert in the cycle after ack.
  - A req still high in IDLE after GAP is treated as a new request.
- An increment of 0 is legal: it performs the write and produces an ack.

## Timing
- Reset values: port_ack=0, cpu_ack=0, cpu_dout=0, init_done=0, last_grant=NPORTS-1 (so port 0 wins first), state=CLR.
- The clear sweep takes 128 cycles. init_done rises in the first IDLE cycle.
- Port update: req sampled in IDLE at cycle T → RD at T+1 → port_ack high at T+2 → GAP at T+3 → IDLE at T+4. Throughput is one update per 4 cycles.
- CPU read: same profile, with cpu_ack and the new cpu_dout at T+2.
- Simultaneous cpu_req and port_req in IDLE: the CPU is served first. Ports are served on subsequent IDLE visits unless cpu_req stays high.
- A CPU read of an address updated in the immediately preceding WR returns the post-update value: the write completes before the next RAM read.
- rst asserted mid-operation:
  - Any pending grant is dropped with no ack.
  - cpu_dout clears to 0.
  - The sweep restarts from address 0.

## Configuration
- STAT_CLR_ON_READ_EN defined: CWR also writes 0 to the read address (read-and-clear, atomic with respect to port updates). A port update to the same address that follows the CPU read accumulates from 0.
- STAT_CLR_ON_READ_EN undefined: CPU reads are non-destructive, and the CWR cycle performs no write.

## Structure
- Package stat_pkg holds:
  - state enum;
  - constants STAT_AW=7, STAT_DW=32, STAT_IW=16, STAT_DEPTH=128;
  - function sat_add(32-bit, 16-bit) returning 32 bits.
- Sub-module stat_rr_arb: NPORTS-wide round-robin arbiter.
  - Inputs: req vector, last_grant.
  - Outputs: grant index and any_req.
  - Combinational search; last_grant is updated by the parent in WR.

## Test plan
- Reset release → init_done rises 128 cycles after rst falls; a CPU read of address 0x7F returns 0.
- Port 1 sends addr=0x10, din=5, three times; CPU reads 0x10 → cpu_dout=15. Each port_ack[1] arrives 2 cycles after req is sampled in IDLE.
- All four ports hold req, each to a distinct address → acks arrive in order 0,1,2,3,0… with 4 cycles between acks.
- Counter preloaded to 0xFFFF_FFF0; port adds 0x20 → read returns 0xFFFF_FFFF, and a further add keeps it there.
- cpu_req and port_req[2] asserted in the same IDLE cycle → cpu_ack comes first, port_ack[2] 4 cycles later. With STAT_CLR_ON_READ_EN, a second read of the same address returns only the port increment.
- rst pulsed during RD of a port update → no port_ack, the counter is not incremented, and the clear sweep restarts.
